// File: rtl/multi_debouncer_if.sv
// Signal bundle for multi_debouncer: sample strobe and raw inputs in,
// debounced levels, edge pulses and busy flags out.
interface multi_debouncer_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                SampleEn;
  logic [CHANNELS-1:0] DataIn;
  logic [CHANNELS-1:0] DataOut;
  logic [CHANNELS-1:0] Rise;
  logic [CHANNELS-1:0] Fall;
  logic [CHANNELS-1:0] Busy;
  logic                Changed;

  modport master (
    output SampleEn, DataIn,
    input  DataOut, Rise, Fall, Busy, Changed
  );

  modport slave (
    input  SampleEn, DataIn,
    output DataOut, Rise, Fall, Busy, Changed
  );
endinterface

// File: rtl/multi_debouncer.sv
// Per-channel synchroniser plus symmetric counting debouncer. Each output flips only after
// STABLE_SAMPLES consecutive strobed samples that disagree with it.
module multi_debouncer #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  multi_debouncer_if.slave    bus
);

  localparam int unsigned   CntW   = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_SAMPLES - 1);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CntW-1:0]     r_cnt  [CHANNELS];
  logic [CntW-1:0]     w_cnt_d[CHANNELS];
  logic [CHANNELS-1:0] r_out, w_out_d;
  logic [CHANNELS-1:0] r_rise, w_rise_d;
  logic [CHANNELS-1:0] r_fall, w_fall_d;
  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_busy;

  // Synchroniser runs every clock, independent of the sample strobe.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.DataIn;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_out_d  = r_out;
    w_rise_d = '0;
    w_fall_d = '0;
    w_busy   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_d[i] = r_cnt[i];
      w_busy[i]  = (r_cnt[i] != '0);
      if (bus.SampleEn) begin
        if (w_s[i] == r_out[i]) begin
          w_cnt_d[i] = '0;
        end else if (r_cnt[i] == CntMax) begin
          // Disagreement has persisted long enough: adopt the synchronised level.
          w_out_d[i]  = w_s[i];
          w_cnt_d[i]  = '0;
          w_rise_d[i] = w_s[i];
          w_fall_d[i] = ~w_s[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= w_cnt_d[i];
      r_out  <= w_out_d;
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
    end
  end

  assign bus.DataOut = r_out;
  assign bus.Rise    = r_rise;
  assign bus.Fall    = r_fall;
  assign bus.Busy    = w_busy;
  assign bus.Changed = |(r_rise | r_fall);

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with CHANNELS=4, STABLE_SAMPLES=4, SYNC_STAGES=2.
module tb_multi_debouncer;

  logic Clock;
  logic Reset;
  int   total;
  int   bad;

  multi_debouncer_if #(.CHANNELS(4)) bus ();

  multi_debouncer #(
    .CHANNELS       (4),
    .STABLE_SAMPLES (4),
    .SYNC_STAGES    (2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] out, input logic [3:0] rise,
                           input logic [3:0] fall, input logic [3:0] busy, input logic chg);
    check({tag, ".DataOut"}, 32'(bus.DataOut), 32'(out));
    check({tag, ".Rise"},    32'(bus.Rise),    32'(rise));
    check({tag, ".Fall"},    32'(bus.Fall),    32'(fall));
    check({tag, ".Busy"},    32'(bus.Busy),    32'(busy));
    check({tag, ".Changed"}, 32'(bus.Changed), 32'(chg));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    Reset        = 1'b1;
    bus.SampleEn = 1'b1;
    bus.DataIn   = 4'b0000;
    step(3);
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    Reset = 1'b0;
    step(2);
    check_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Clean press on channel 0: DataOut rises at edge 6.
    bus.DataIn = 4'b0001;
    step(5);
    check_all("press_e5", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    step(1);
    check_all("press_e6", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(1);
    check_all("press_e7", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Bounce on channel 1: 1 x3, 0 x1, then 1 held.
    bus.DataIn = 4'b0011;
    step(3);
    check_all("bounce_e3", 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    bus.DataIn = 4'b0001;
    step(1);
    bus.DataIn = 4'b0011;
    step(1);
    check_all("bounce_e5", 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    step(1);
    check_all("bounce_glitch", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(3);
    check_all("bounce_e9", 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    step(1);
    check_all("bounce_rise", 4'b0011, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    step(1);

    // Short dip on channel 0 is rejected.
    bus.DataIn = 4'b0010;
    step(2);
    bus.DataIn = 4'b0011;
    step(4);
    check_all("short_dip", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Long dip on channel 0 produces a Fall pulse.
    bus.DataIn = 4'b0010;
    step(5);
    check_all("long_dip_e5", 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    step(1);
    check_all("long_dip_fall", 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    step(1);
    check_all("long_dip_after", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Strobed sampling every 10th cycle on channel 2.
    bus.DataIn   = 4'b0110;
    bus.SampleEn = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(9);
      check("strobe_gap.DataOut", 32'(bus.DataOut), 32'(4'b0010));
      check("strobe_gap.Rise", 32'(bus.Rise), 32'(4'b0000));
      bus.SampleEn = 1'b1;
      step(1);
      bus.SampleEn = 1'b0;
      check("strobe_hit.DataOut", 32'(bus.DataOut), 32'(4'b0010));
      check("strobe_hit.Busy", 32'(bus.Busy), 32'(4'b0100));
    end
    step(9);
    check_all("strobe_hold", 4'b0010, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    bus.SampleEn = 1'b1;
    step(1);
    bus.SampleEn = 1'b0;
    check_all("strobe_rise", 4'b0110, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    step(1);
    check_all("strobe_after", 4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    bus.SampleEn = 1'b1;

    // Return everything to 0, then a simultaneous press on all channels.
    bus.DataIn = 4'b0000;
    step(6);
    check_all("all_fall", 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1'b1);
    step(1);
    bus.DataIn = 4'b1111;
    step(5);
    check_all("simul_e5", 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    step(1);
    check_all("simul_rise", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    step(1);

    // Reset asserted mid-count with all inputs held high.
    bus.DataIn = 4'b0000;
    step(7);
    check("clear.DataOut", 32'(bus.DataOut), 32'(4'b0000));
    bus.DataIn = 4'b1111;
    step(4);
    check_all("pre_reset", 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    check_all("reset_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    Reset = 1'b0;
    step(5);
    check_all("post_reset_e5", 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    step(1);
    check_all("post_reset_rise", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    step(1);
    check_all("post_reset_after", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent debounced inputs, legal range 1..32.
REQ-002 Parameter STABLE_SAMPLES, default 4: consecutive qualifying samples needed to change an output, legal range 1..65535.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, legal range 2..4.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-high reset; clock Clock.
REQ-006 SampleEn  input  1  sample strobe; the debounce logic advances only in cycles where it is 1; tie to 1 for per-clock sampling.
REQ-007 DataIn  input  CHANNELS  raw asynchronous inputs (switches, keys).
REQ-008 DataOut  output  CHANNELS  debounced levels, registered.
REQ-009 Rise  output  CHANNELS  one-cycle pulse when the matching DataOut goes 0->1.
REQ-010 Fall  output  CHANNELS  one-cycle pulse when the matching DataOut goes 1->0.
REQ-011 Busy  output  CHANNELS  1 while that channel's disagreement counter is nonzero.
REQ-012 Changed  output  1  OR of all Rise and Fall bits.

Function
REQ-013 Each channel shall pass DataIn[i] through a SYNC_STAGES-deep flop chain on every clock, independent of SampleEn; s[i] is the last stage.
REQ-014 Each channel shall keep a counter wide enough to hold STABLE_SAMPLES-1.
REQ-015 In a cycle with SampleEn=1 and s[i]==DataOut[i], the counter shall clear to 0.
REQ-016 In a cycle with SampleEn=1, s[i]!=DataOut[i] and counter<STABLE_SAMPLES-1, the counter shall increment by 1.
REQ-017 In a cycle with SampleEn=1, s[i]!=DataOut[i] and counter==STABLE_SAMPLES-1, DataOut[i] shall invert, the counter shall clear, and Rise[i] or Fall[i] shall be 1 in the following cycle only.
REQ-018 Both edges shall be debounced symmetrically; a single disagreeing sample shall never change DataOut when STABLE_SAMPLES>1.
REQ-019 With STABLE_SAMPLES=1, DataOut shall follow s on every sample.
REQ-020 In a cycle with SampleEn=0, counters and DataOut shall hold and Rise/Fall shall be 0.
REQ-021 Latency with SampleEn held at 1: an input change first captured at edge 1 shall appear on DataOut at edge SYNC_STAGES+STABLE_SAMPLES, provided the input stays stable.
REQ-022 A glitch that returns to the DataOut level before the threshold is reached shall restart the count from 0 on the next disagreement.
REQ-023 Channels shall be fully independent; any number of Rise/Fall bits may be 1 in the same cycle.
REQ-024 Rise and Fall for one channel shall never be 1 together.
REQ-025 Rise and Fall shall be registered pulses; Changed shall be their combinational OR.

Reset
REQ-026 Reset=1 shall asynchronously clear all synchroniser stages, counters, DataOut, Rise, Fall and Busy to 0.
REQ-027 Reset asserted mid-count shall discard the count, and shall produce no Rise or Fall pulse on assertion or on release.
REQ-028 After release with DataIn[i]=1 held, DataOut[i] shall rise as a normal debounced edge: a Rise pulse after SYNC_STAGES+STABLE_SAMPLES sampling edges.

Verification (CHANNELS=4, STABLE_SAMPLES=4, SYNC_STAGES=2, SampleEn=1 unless stated)
REQ-029 Clean press: DataIn 0000->0001, held -> DataOut[0] rises at edge 6, Rise=0001 for exactly one cycle, Changed=1 in that cycle.
REQ-030 Bounce: DataIn[1] goes 1 for 3 cycles, 0 for 1 cycle, then 1 held -> no change during the bounce; DataOut[1] rises 6 edges after the final 0->1; Busy[1] returns to 0 at the glitch.
REQ-031 Release debounce: DataOut=0001, DataIn[0] dips to 0 for 2 cycles -> DataOut holds; a dip of 4+ cycles -> Fall[0] pulse and DataOut=0000.
REQ-032 Strobe: SampleEn=1 every 10th cycle, DataIn[2]=1 held -> DataOut[2] rises on the 4th strobe after the sync delay, with no change between strobes.
REQ-033 Simultaneous and reset: DataIn 0000->1111 -> Rise=1111 in one cycle; Reset pulsed at count 2 with input held -> all outputs 0 immediately, no pulse, then Rise=1111 6 edges after release.
